// File: rtl/dds_ctrl_pkg.sv
// Shared types and default widths for the multi-channel DDS apply controller.
package dds_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } ch_state_t;

  localparam int unsigned FTW_W      = 32;
  localparam int unsigned WSEL_W     = 3;
  localparam int unsigned PHASE_W    = 12;
  localparam int unsigned HOLD_CNT_W = 8;

endpackage

// File: rtl/dds_ch_seq.sv
// Per-channel restart sequencer: edge detect, IDLE/PEND/HOLD FSM, hold-off counter,
// single-entry requeue and sticky overrun flag.
module dds_ch_seq
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned HOLDOFF = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      restart_req,
  input  logic      go,
  input  logic      overrun_clr,
  output ch_state_t state,
  output logic      apply,
  output logic      overrun
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD =
    HOLD_CNT_W'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

  ch_state_t             state_nxt;
  logic                  req_d;
  logic                  trig;
  logic                  requeue, requeue_nxt;
  logic                  overrun_set;
  logic [HOLD_CNT_W-1:0] cnt, cnt_nxt;

  assign trig = restart_req & ~req_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_d   <= 1'b0;
      requeue <= 1'b0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      req_d   <= restart_req;
      requeue <= requeue_nxt;
      cnt     <= cnt_nxt;
      overrun <= overrun_set | (overrun & ~overrun_clr);
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    requeue_nxt = requeue;
    apply       = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: if (trig) state_nxt = PEND;
      PEND: begin
        if (go) begin
          apply = 1'b1;
          if (HOLDOFF == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_LOAD;
          end
        end
      end
      HOLD: begin
        if (trig) begin
          if (requeue) overrun_set = 1'b1;
          else         requeue_nxt = 1'b1;
        end
        // A trigger landing on the expiry cycle still re-enters PEND.
        if (cnt == '0) begin
          state_nxt   = (requeue | trig) ? PEND : IDLE;
          requeue_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - HOLD_CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/dds_multi_apply_ctrl.sv
// Multi-channel DDS restart/apply controller: per-channel sequencers, lock-step group go,
// and config capture registers. Optional phase capture under macro DDS_PHASE_OFS_EN.
module dds_multi_apply_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned FTW_W   = dds_ctrl_pkg::FTW_W,
  parameter int unsigned WSEL_W  = dds_ctrl_pkg::WSEL_W,
  parameter int unsigned PHASE_W = dds_ctrl_pkg::PHASE_W,
  parameter int unsigned HOLDOFF = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         restart_req,
  input  logic [NUM_CH*WSEL_W-1:0]  cfg_wave_sel,
  input  logic [NUM_CH*FTW_W-1:0]   cfg_ftw,
  input  logic [NUM_CH*PHASE_W-1:0] cfg_phase,
  input  logic                      sync_mode,
  input  logic [NUM_CH-1:0]         core_ready,
  input  logic                      overrun_clr,
  output logic [NUM_CH*WSEL_W-1:0]  wave_sel_out,
  output logic [NUM_CH*FTW_W-1:0]   ftw_out,
  output logic [NUM_CH*PHASE_W-1:0] phase_out,
  output logic [NUM_CH-1:0]         apply_pulse,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         overrun
);

  ch_state_t         st [NUM_CH];
  logic [NUM_CH-1:0] go;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] in_pend;
  logic [NUM_CH-1:0] grp_ok;
  logic              group_go;

  // Group fires only when no channel is holding and every pending channel is ready.
  always_comb begin
    in_pend = '0;
    grp_ok  = '0;
    busy    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      in_pend[i] = (st[i] == PEND);
      grp_ok[i]  = (st[i] == IDLE) | (in_pend[i] & core_ready[i]);
      busy[i]    = (st[i] != IDLE);
    end
    group_go = (&grp_ok) & (|in_pend);
    go       = sync_mode ? {NUM_CH{group_go}} : core_ready;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dds_ch_seq #(.HOLDOFF(HOLDOFF)) u_seq (
      .clk         (clk),
      .rst_n       (rst_n),
      .restart_req (restart_req[g]),
      .go          (go[g]),
      .overrun_clr (overrun_clr),
      .state       (st[g]),
      .apply       (apply[g]),
      .overrun     (overrun[g])
    );
  end

  assign apply_pulse = apply;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_sel_out <= '0;
      ftw_out      <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (apply[i]) begin
          wave_sel_out[i*WSEL_W +: WSEL_W] <= cfg_wave_sel[i*WSEL_W +: WSEL_W];
          ftw_out[i*FTW_W +: FTW_W]        <= cfg_ftw[i*FTW_W +: FTW_W];
        end
      end
    end
  end

`ifdef DDS_PHASE_OFS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_out <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (apply[i]) phase_out[i*PHASE_W +: PHASE_W] <= cfg_phase[i*PHASE_W +: PHASE_W];
      end
    end
  end
`else
  logic unused_phase;
  assign unused_phase = ^cfg_phase;
  assign phase_out    = '0;
`endif

endmodule

// File: tb/tb_dds_multi_apply_ctrl.sv
// Self-checking bench for dds_multi_apply_ctrl: directed scenarios then random traffic
// against a per-channel behavioural model (pending flag, hold countdown, queue, sticky overrun).
module tb_dds_multi_apply_ctrl;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned FTW_W   = 32;
  localparam int unsigned WSEL_W  = 3;
  localparam int unsigned PHASE_W = 12;
  localparam int unsigned HOLDOFF = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_CH-1:0]         restart_req;
  logic [NUM_CH*WSEL_W-1:0]  cfg_wave_sel;
  logic [NUM_CH*FTW_W-1:0]   cfg_ftw;
  logic [NUM_CH*PHASE_W-1:0] cfg_phase;
  logic                      sync_mode;
  logic [NUM_CH-1:0]         core_ready;
  logic                      overrun_clr;
  logic [NUM_CH*WSEL_W-1:0]  wave_sel_out;
  logic [NUM_CH*FTW_W-1:0]   ftw_out;
  logic [NUM_CH*PHASE_W-1:0] phase_out;
  logic [NUM_CH-1:0]         apply_pulse;
  logic [NUM_CH-1:0]         busy;
  logic [NUM_CH-1:0]         overrun;

  dds_multi_apply_ctrl #(
    .NUM_CH (NUM_CH),
    .FTW_W  (FTW_W),
    .WSEL_W (WSEL_W),
    .PHASE_W(PHASE_W),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .restart_req  (restart_req),
    .cfg_wave_sel (cfg_wave_sel),
    .cfg_ftw      (cfg_ftw),
    .cfg_phase    (cfg_phase),
    .sync_mode    (sync_mode),
    .core_ready   (core_ready),
    .overrun_clr  (overrun_clr),
    .wave_sel_out (wave_sel_out),
    .ftw_out      (ftw_out),
    .phase_out    (phase_out),
    .apply_pulse  (apply_pulse),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  bit               m_pend [NUM_CH];
  int               m_hold [NUM_CH];
  bit               m_q    [NUM_CH];
  bit               m_ovr  [NUM_CH];
  bit               m_prev [NUM_CH];
  logic [FTW_W-1:0]   m_ftw   [NUM_CH];
  logic [WSEL_W-1:0]  m_wave  [NUM_CH];
  logic [PHASE_W-1:0] m_phase [NUM_CH];
  logic [NUM_CH-1:0]  exp_apply;
  logic [NUM_CH-1:0]  seen_apply;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pend[i] = 0; m_hold[i] = 0; m_q[i] = 0; m_ovr[i] = 0; m_prev[i] = 0;
      m_ftw[i] = '0; m_wave[i] = '0; m_phase[i] = '0;
    end
  endtask

  // Negedge: compare every output with the model for the current inputs.
  task automatic check_outputs();
    bit all_ok, any_p;
    logic [NUM_CH-1:0]         e_busy, e_ovr;
    logic [NUM_CH*FTW_W-1:0]   e_ftw;
    logic [NUM_CH*WSEL_W-1:0]  e_wave;
    logic [NUM_CH*PHASE_W-1:0] e_phase;
    all_ok = 1; any_p = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_hold[i] > 0) all_ok = 0;
      if (m_pend[i]) begin
        any_p = 1;
        if (!core_ready[i]) all_ok = 0;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      exp_apply[i] = rst_n && m_pend[i] && (sync_mode ? (all_ok && any_p) : core_ready[i]);
      e_busy[i]    = m_pend[i] || (m_hold[i] > 0);
      e_ovr[i]     = m_ovr[i];
      e_ftw[i*FTW_W +: FTW_W]       = m_ftw[i];
      e_wave[i*WSEL_W +: WSEL_W]    = m_wave[i];
`ifdef DDS_PHASE_OFS_EN
      e_phase[i*PHASE_W +: PHASE_W] = m_phase[i];
`else
      e_phase[i*PHASE_W +: PHASE_W] = '0;
`endif
    end
    seen_apply = apply_pulse;
    chk("apply_pulse", 64'(apply_pulse), 64'(exp_apply));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("overrun", 64'(overrun), 64'(e_ovr));
    chk("ftw_out", 64'(ftw_out), 64'(e_ftw));
    chk("wave_sel_out", 64'(wave_sel_out), 64'(e_wave));
    chk("phase_out", 64'(phase_out), 64'(e_phase));
  endtask

  // Posedge: advance the model by one clock using the same inputs.
  task automatic model_step();
    bit trig, set_ovr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      trig = restart_req[i] && !m_prev[i];
      set_ovr = 0;
      if (exp_apply[i]) begin
        m_pend[i]  = 0;
        m_hold[i]  = HOLDOFF;
        m_ftw[i]   = cfg_ftw[i*FTW_W +: FTW_W];
        m_wave[i]  = cfg_wave_sel[i*WSEL_W +: WSEL_W];
        m_phase[i] = cfg_phase[i*PHASE_W +: PHASE_W];
      end else if (m_pend[i]) begin
        // further edges merge into the pending request
      end else if (m_hold[i] > 0) begin
        if (trig) begin
          if (m_q[i]) set_ovr = 1;
          else        m_q[i] = 1;
        end
        m_hold[i]--;
        if (m_hold[i] == 0) begin
          m_pend[i] = m_q[i];
          m_q[i]    = 0;
        end
      end else if (trig) begin
        m_pend[i] = 1;
      end
      m_ovr[i]  = set_ovr || (m_ovr[i] && !overrun_clr);
      m_prev[i] = restart_req[i];
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int cnt;
    bit found;
    rst_n = 1'b0; restart_req = '0; cfg_wave_sel = '0; cfg_ftw = '0; cfg_phase = '0;
    sync_mode = 1'b0; core_ready = '0; overrun_clr = 1'b0;
    model_reset();
    cycles(3);
    chk("reset_ftw", 64'(ftw_out), 64'd0);
    rst_n = 1'b1;
    cycles(2);

    // 1. single request, with phase value for the optional phase path
    core_ready = 2'b11;
    cfg_ftw[31:0] = 32'h0123_4567;
    cfg_wave_sel[2:0] = 3'd2;
    cfg_phase[11:0] = 12'h3FF;
    restart_req[0] = 1'b1;
    cycle();
    chk("t1_no_pulse_trig_cycle", 64'(seen_apply), 64'd0);
    cycle();
    chk("t1_pulse", 64'(seen_apply), 64'd1);
    cycle();
    chk("t1_no_second_pulse", 64'(seen_apply), 64'd0);
    chk("t1_ftw", 64'(ftw_out[31:0]), 64'h0123_4567);
    chk("t1_wave", 64'(wave_sel_out[2:0]), 64'd2);
`ifdef DDS_PHASE_OFS_EN
    chk("t6_phase", 64'(phase_out[11:0]), 64'h3FF);
`else
    chk("t6_phase_off", 64'(phase_out), 64'd0);
`endif
    restart_req = '0;
    cycles(8);

    // 2. not ready for 10 cycles; config updated while pending
    core_ready[0] = 1'b0;
    restart_req[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) cfg_ftw[31:0] = 32'h0000_A5A5;
      cycle();
    end
    core_ready[0] = 1'b1;
    cycle();
    chk("t2_pulse_on_ready", 64'(seen_apply), 64'd1);
    cycle();
    chk("t2_ftw", 64'(ftw_out[31:0]), 64'h0000_A5A5);
    restart_req = '0;
    cycles(8);

    // 3. apply, then requeue, then overrun
    restart_req[0] = 1'b1; cycle();
    restart_req[0] = 1'b0; cycle();
    chk("t3_first_pulse", 64'(seen_apply[0]), 64'd1);
    restart_req[0] = 1'b1; cycle();
    restart_req[0] = 1'b0; cycle();
    restart_req[0] = 1'b1; cycle();
    restart_req[0] = 1'b0; cycle();
    chk("t3_overrun_set", 64'(overrun[0]), 64'd1);
    cycles(12);
    overrun_clr = 1'b1; cycle();
    overrun_clr = 1'b0; cycle();
    chk("t3_overrun_clr", 64'(overrun[0]), 64'd0);
    cycles(8);

    // 4. lock-step apply
    sync_mode = 1'b1; core_ready = 2'b00;
    restart_req[0] = 1'b1; cycles(3);
    restart_req[1] = 1'b1; cycles(2);
    core_ready[0] = 1'b1; cycles(5);
    core_ready[1] = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (seen_apply != '0) found = 1;
    end
    chk("t4_found_pulse", 64'(found), 64'd1);
    chk("t4_lockstep", 64'(seen_apply), 64'd3);
    restart_req = '0; sync_mode = 1'b0;
    cycles(8);

    // 5. reset mid-PEND with request held high
    core_ready = 2'b00;
    restart_req[0] = 1'b1;
    cycles(3);
    rst_n = 1'b0; model_reset();
    cycles(2);
    chk("t5_reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1; core_ready = 2'b11;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (seen_apply[0]) cnt++;
    end
    chk("t5_one_pulse", 64'(cnt), 64'd1);
    restart_req = '0;
    cycles(8);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      if (k % 250 == 0) sync_mode = 1'($urandom_range(1, 0));
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(2, 0) == 0) restart_req[i] = ~restart_req[i];
        core_ready[i] = ($urandom_range(9, 0) < 7);
      end
      cfg_ftw      = {$urandom, $urandom};
      cfg_wave_sel = 6'($urandom);
      cfg_phase    = 24'($urandom);
      overrun_clr  = ($urandom_range(19, 0) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
